banner_cmd_ctrl: RTL and testbench
==================================

BANNER_CMD_CTRL -- requirements
Module: banner_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6: number of 4-bit BCD banner digits.
REQ-002 The block SHALL have parameter BAUD_DEFAULT, default 0: baud index driven from reset until a baud byte is accepted.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port rx_data, input, 8, received UART byte (ASCII).
REQ-006 The block SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 The block SHALL have port baud_sel, output, 3, baud-rate index for the UART receiver.
REQ-008 The block SHALL have port baud_rate_ready, output, 1, high once a baud index has been accepted.
REQ-009 The block SHALL have port banner_write, output, 1, high while digits are being staged.
REQ-010 The block SHALL have port bcd_set, output, 4*DIGITS, committed digits; digit 0 is in bits [3:0].
REQ-011 The block SHALL have port shift_en, output, 1, scroll enable for the BCD shift register.
REQ-012 The block SHALL have port err, output, 1, one-cycle pulse on a rejected byte.

Function
REQ-013 The block SHALL implement the states BAUD_WAIT, IDLE, WRITE and RUN, and SHALL process only bytes with rx_valid=1.
REQ-014 Every accepted byte SHALL update the state and outputs on the same clock edge, so the response is visible the cycle after the strobe; there is no backpressure.
REQ-015 In BAUD_WAIT, a byte '0'..'7' (0x30-0x37) SHALL load baud_sel with byte-0x30, set baud_rate_ready=1 and go to IDLE; any other byte SHALL pulse err and remain in BAUD_WAIT.
REQ-016 In IDLE or RUN, 'w' SHALL enter WRITE, clear the staging buffer and digit count, and set banner_write=1.
REQ-017 In IDLE or RUN, 'b' SHALL enter BAUD_WAIT, clear baud_rate_ready and shift_en, and hold baud_sel and bcd_set unchanged.
REQ-018 In RUN, 'p' SHALL clear shift_en and go to IDLE; in IDLE, 'r' SHALL set shift_en and go to RUN only if at least one commit has occurred since reset, else it SHALL pulse err.
REQ-019 In WRITE, a digit '0'..'9' SHALL shift the staging buffer left by one nibble, insert the value at bits [3:0], and increment the count, saturating at DIGITS.
REQ-020 When more than DIGITS digits are received, the oldest digit SHALL be discarded with no err.
REQ-021 In WRITE, 's' with count>=1 SHALL copy staging to bcd_set, with unfilled high nibbles zero, clear banner_write, set shift_en, and go to RUN.
REQ-022 In WRITE, 's' with count=0 SHALL pulse err, leave bcd_set unchanged, clear banner_write, and return to IDLE with shift_en=0.
REQ-023 In WRITE, 'x' SHALL discard staging, clear banner_write, and return to IDLE with shift_en=0.
REQ-024 Any byte not listed above for the current state SHALL pulse err and cause no other change.
REQ-025 bcd_set SHALL change only on a successful commit.
REQ-026 err SHALL be high for exactly one cycle per rejected byte; back-to-back rejected bytes SHALL produce back-to-back pulses.

Reset
REQ-027 While reset=1, the block SHALL go to BAUD_WAIT with baud_sel=BAUD_DEFAULT, baud_rate_ready=0, banner_write=0, bcd_set=0, shift_en=0, err=0, staging=0, count=0 and the commit flag cleared.
REQ-028 Reset SHALL take priority over a simultaneous rx_valid, and that byte SHALL be dropped.
REQ-029 Reset asserted mid-WRITE SHALL discard staging with no partial commit.

Verification
REQ-030 The bench SHALL cover: reset, then '5' -> baud_sel=5 and baud_rate_ready=1 on the next cycle; reset, then 'q' -> err pulse and baud_rate_ready stays 0.
REQ-031 The bench SHALL cover: after the baud byte, "w340340s" -> banner_write=1 from 'w' to 's', then bcd_set=0x340340 (DIGITS=6) and shift_en=1.
REQ-032 The bench SHALL cover: "w12345678s" -> bcd_set=0x345678 with no err; "w7s" -> bcd_set=0x000007.
REQ-033 The bench SHALL cover: "ws" -> one err pulse, bcd_set unchanged, state IDLE; "w12x" -> bcd_set unchanged and shift_en=0.
REQ-034 The bench SHALL cover: from RUN, 'p' -> shift_en=0, then 'r' -> shift_en=1; and 'r' right after reset plus baud -> err.
REQ-035 The bench SHALL cover: reset asserted in the same cycle as rx_valid with 's' mid-WRITE -> all outputs at reset values and bcd_set=0.

Source files
------------

// File: rtl/banner_cmd_ctrl.sv
// Banner command controller: decodes UART command bytes into baud
// selection, BCD banner staging/commit and scroll-enable control.
module banner_cmd_ctrl #(
    parameter int DIGITS       = 6,
    parameter int BAUD_DEFAULT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [2:0]            baud_sel,
    output logic                  baud_rate_ready,
    output logic                  banner_write,
    output logic [4*DIGITS-1:0]   bcd_set,
    output logic                  shift_en,
    output logic                  err
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        BAUD_WAIT = 2'd0,
        IDLE      = 2'd1,
        WRITE     = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      baud_sel_q, baud_sel_d;
    logic            ready_q, ready_d;
    logic            bw_q, bw_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            shift_q, shift_d;
    logic            err_q, err_d;
    logic [BW-1:0]   stage_q, stage_d;
    logic [CW-1:0]   count_q, count_d;
    logic            committed_q, committed_d;

    logic is_baud;
    logic is_digit;
    logic is_w;
    logic is_b;
    logic is_p;
    logic is_r;
    logic is_s;
    logic is_x;

    // Classify the incoming byte once so the FSM reads as intent.
    always_comb begin
        is_baud  = (rx_data >= 8'h30) && (rx_data <= 8'h37);
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_w     = (rx_data == 8'h77);
        is_b     = (rx_data == 8'h62);
        is_p     = (rx_data == 8'h70);
        is_r     = (rx_data == 8'h72);
        is_s     = (rx_data == 8'h73);
        is_x     = (rx_data == 8'h78);
    end

    // Next-state and output decode; idle cycles hold everything but err.
    always_comb begin
        state_d     = state_q;
        baud_sel_d  = baud_sel_q;
        ready_d     = ready_q;
        bw_d        = bw_q;
        bcd_d       = bcd_q;
        shift_d     = shift_q;
        err_d       = 1'b0;
        stage_d     = stage_q;
        count_d     = count_q;
        committed_d = committed_q;

        if (rx_valid) begin
            unique case (state_q)
                BAUD_WAIT: begin
                    if (is_baud) begin
                        baud_sel_d = rx_data[2:0];
                        ready_d    = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end

                IDLE, RUN: begin
                    unique case (1'b1)
                        is_w: begin
                            state_d = WRITE;
                            stage_d = '0;
                            count_d = '0;
                            bw_d    = 1'b1;
                        end
                        is_b: begin
                            state_d = BAUD_WAIT;
                            ready_d = 1'b0;
                            shift_d = 1'b0;
                        end
                        (is_p && state_q == RUN): begin
                            shift_d = 1'b0;
                            state_d = IDLE;
                        end
                        (is_r && state_q == IDLE && committed_q): begin
                            shift_d = 1'b1;
                            state_d = RUN;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end

                WRITE: begin
                    unique case (1'b1)
                        is_digit: begin
                            // Oldest nibble falls off the top on overflow.
                            stage_d      = stage_q << 4;
                            stage_d[3:0] = rx_data[3:0];
                            if (count_q < CW'(DIGITS)) begin
                                count_d = count_q + CW'(1);
                            end
                        end
                        is_s: begin
                            bw_d = 1'b0;
                            if (count_q != '0) begin
                                bcd_d       = stage_q;
                                shift_d     = 1'b1;
                                committed_d = 1'b1;
                                state_d     = RUN;
                            end else begin
                                err_d   = 1'b1;
                                shift_d = 1'b0;
                                state_d = IDLE;
                            end
                        end
                        is_x: begin
                            bw_d    = 1'b0;
                            stage_d = '0;
                            count_d = '0;
                            shift_d = 1'b0;
                            state_d = IDLE;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end

                default: begin
                    state_d = BAUD_WAIT;
                end
            endcase
        end
    end

    // State register; reset wins over any byte arriving the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BAUD_WAIT;
            baud_sel_q  <= 3'(BAUD_DEFAULT);
            ready_q     <= 1'b0;
            bw_q        <= 1'b0;
            bcd_q       <= '0;
            shift_q     <= 1'b0;
            err_q       <= 1'b0;
            stage_q     <= '0;
            count_q     <= '0;
            committed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_sel_q  <= baud_sel_d;
            ready_q     <= ready_d;
            bw_q        <= bw_d;
            bcd_q       <= bcd_d;
            shift_q     <= shift_d;
            err_q       <= err_d;
            stage_q     <= stage_d;
            count_q     <= count_d;
            committed_q <= committed_d;
        end
    end

    assign baud_sel        = baud_sel_q;
    assign baud_rate_ready = ready_q;
    assign banner_write    = bw_q;
    assign bcd_set         = bcd_q;
    assign shift_en        = shift_q;
    assign err             = err_q;

endmodule

// File: tb/tb_banner_cmd_ctrl.sv
// Directed bench for banner_cmd_ctrl: baud, write/commit, overflow,
// abort, pause/resume, rebaud and reset-during-write scenarios.
module tb_banner_cmd_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  baud_sel;
    logic        baud_rate_ready;
    logic        banner_write;
    logic [23:0] bcd_set;
    logic        shift_en;
    logic        err;

    int checks;
    int errors;

    banner_cmd_ctrl #(.DIGITS(6), .BAUD_DEFAULT(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .baud_sel        (baud_sel),
        .baud_rate_ready (baud_rate_ready),
        .banner_write    (banner_write),
        .bcd_set         (bcd_set),
        .shift_en        (shift_en),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge with the response visible.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (baud_sel !== 3'd0 || baud_rate_ready !== 1'b0 ||
            banner_write !== 1'b0 || bcd_set !== 24'h0 ||
            shift_en !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got sel=%0d rdy=%b bw=%b bcd=%h sh=%b err=%b exp 0/0/0/0/0/0",
                     baud_sel, baud_rate_ready, banner_write, bcd_set, shift_en, err);
        end
    endtask

    task automatic test_baud_bad();
        send(8'h71);
        checks++;
        if (err !== 1'b1 || baud_rate_ready !== 1'b0) begin
            errors++;
            $display("FAIL baud_bad got err=%b rdy=%b exp err=1 rdy=0", err, baud_rate_ready);
        end
        send(8'h7a);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_back_to_back got %b exp 1", err);
        end
        idle();
        checks++;
        if (err !== 1'b0 || baud_rate_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle got err=%b rdy=%b exp 0 0", err, baud_rate_ready);
        end
    endtask

    task automatic test_baud_good();
        send(8'h35);
        checks++;
        if (baud_sel !== 3'd5 || baud_rate_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL baud_good got sel=%0d rdy=%b err=%b exp 5 1 0",
                     baud_sel, baud_rate_ready, err);
        end
    endtask

    task automatic test_run_no_commit();
        send(8'h72);
        checks++;
        if (err !== 1'b1 || shift_en !== 1'b0) begin
            errors++;
            $display("FAIL run_no_commit got err=%b sh=%b exp 1 0", err, shift_en);
        end
    endtask

    task automatic test_write();
        logic [7:0] digs [6];
        logic       bw_ok;
        digs = '{8'h33, 8'h34, 8'h30, 8'h33, 8'h34, 8'h30};
        bw_ok = 1'b1;
        send(8'h77);
        bw_ok &= (banner_write === 1'b1);
        for (int i = 0; i < 6; i++) begin
            send(digs[i]);
            bw_ok &= (banner_write === 1'b1) && (err === 1'b0);
        end
        checks++;
        if (!bw_ok) begin
            errors++;
            $display("FAIL write_staging got bw_ok=%b exp 1", bw_ok);
        end
        send(8'h73);
        checks++;
        if (bcd_set !== 24'h340340 || shift_en !== 1'b1 ||
            banner_write !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_commit got bcd=%h sh=%b bw=%b err=%b exp 340340 1 0 0",
                     bcd_set, shift_en, banner_write, err);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s [10];
        logic       any_err;
        s = '{8'h77, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h73};
        any_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(s[i]);
            any_err |= err;
        end
        checks++;
        if (bcd_set !== 24'h345678 || any_err !== 1'b0 || shift_en !== 1'b1) begin
            errors++;
            $display("FAIL overflow got bcd=%h err_seen=%b sh=%b exp 345678 0 1",
                     bcd_set, any_err, shift_en);
        end
    endtask

    task automatic test_single();
        send(8'h77);
        send(8'h37);
        send(8'h73);
        checks++;
        if (bcd_set !== 24'h000007 || shift_en !== 1'b1) begin
            errors++;
            $display("FAIL single_digit got bcd=%h sh=%b exp 000007 1", bcd_set, shift_en);
        end
    endtask

    task automatic test_pause_resume();
        send(8'h70);
        checks++;
        if (shift_en !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL pause got sh=%b err=%b exp 0 0", shift_en, err);
        end
        send(8'h72);
        checks++;
        if (shift_en !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL resume got sh=%b err=%b exp 1 0", shift_en, err);
        end
    endtask

    task automatic test_empty_commit();
        send(8'h77);
        send(8'h73);
        checks++;
        if (err !== 1'b1 || bcd_set !== 24'h000007 ||
            shift_en !== 1'b0 || banner_write !== 1'b0) begin
            errors++;
            $display("FAIL empty_commit got err=%b bcd=%h sh=%b bw=%b exp 1 000007 0 0",
                     err, bcd_set, shift_en, banner_write);
        end
        idle();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL empty_commit_pulse got %b exp 0", err);
        end
        send(8'h70);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL idle_rejects_p got err=%b exp 1", err);
        end
        send(8'h72);
        checks++;
        if (shift_en !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL idle_r_after_commit got sh=%b err=%b exp 1 0", shift_en, err);
        end
    endtask

    task automatic test_abort();
        send(8'h77);
        send(8'h31);
        send(8'h32);
        send(8'h78);
        checks++;
        if (bcd_set !== 24'h000007 || shift_en !== 1'b0 ||
            banner_write !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL abort got bcd=%h sh=%b bw=%b err=%b exp 000007 0 0 0",
                     bcd_set, shift_en, banner_write, err);
        end
    endtask

    task automatic test_rebaud();
        send(8'h72);
        send(8'h62);
        checks++;
        if (baud_rate_ready !== 1'b0 || shift_en !== 1'b0 ||
            baud_sel !== 3'd5 || bcd_set !== 24'h000007) begin
            errors++;
            $display("FAIL rebaud got rdy=%b sh=%b sel=%0d bcd=%h exp 0 0 5 000007",
                     baud_rate_ready, shift_en, baud_sel, bcd_set);
        end
        send(8'h32);
        checks++;
        if (baud_sel !== 3'd2 || baud_rate_ready !== 1'b1) begin
            errors++;
            $display("FAIL rebaud_load got sel=%0d rdy=%b exp 2 1", baud_sel, baud_rate_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        send(8'h77);
        send(8'h39);
        send(8'h38);
        reset    = 1'b1;
        rx_data  = 8'h73;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        checks++;
        if (baud_sel !== 3'd0 || baud_rate_ready !== 1'b0 ||
            banner_write !== 1'b0 || bcd_set !== 24'h0 ||
            shift_en !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write got sel=%0d rdy=%b bw=%b bcd=%h sh=%b err=%b exp all 0",
                     baud_sel, baud_rate_ready, banner_write, bcd_set, shift_en, err);
        end
        send(8'h31);
        send(8'h72);
        checks++;
        if (err !== 1'b1 || shift_en !== 1'b0) begin
            errors++;
            $display("FAIL commit_flag_cleared got err=%b sh=%b exp 1 0", err, shift_en);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_baud_bad();
        test_baud_good();
        test_run_no_commit();
        test_write();
        test_overflow();
        test_single();
        test_pause_resume();
        test_empty_commit();
        test_abort();
        test_rebaud();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
